// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC-lane sequencer.
package mac_seq_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned RES_W          = 3 * DATA_WIDTH_DEF;
    localparam int unsigned STALL_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        OUTPUT,
        DONE
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + STALL_W'(1);
    endfunction

endpackage

// File: rtl/mac_seq_drain.sv
// Serialises the lane results onto one valid/ready port, lane 0 first.
module mac_seq_drain #(
    parameter int unsigned RES_WIDTH = 24,
    parameter int unsigned NUM_LANES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [NUM_LANES*RES_WIDTH-1:0] cout_i,
    input  logic                           res_ready_i,
    output logic                           res_valid_o,
    output logic [RES_WIDTH-1:0]           res_data_o,
    output logic [$clog2(NUM_LANES)-1:0]   res_lane_o,
    output logic                           last_o
);

    localparam int unsigned LANE_W = $clog2(NUM_LANES);

    logic              active_q, active_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              accept_c;
    logic [RES_WIDTH-1:0] lane_res [NUM_LANES];

    // Split the concatenated lane results into an indexable array.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_res[g] = cout_i[g*RES_WIDTH +: RES_WIDTH];
    end

    assign res_valid_o = active_q & ~rst;
    assign res_data_o  = lane_res[lane_q];
    assign res_lane_o  = lane_q;
    assign accept_c    = res_valid_o & res_ready_i;
    assign last_o      = accept_c & (lane_q == LANE_W'(NUM_LANES - 1));

    // Lane pointer advances only on an accepted beat; the last beat ends the burst.
    always_comb begin
        active_d = active_q;
        lane_d   = lane_q;
        if (start_i) begin
            active_d = 1'b1;
            lane_d   = '0;
        end else if (accept_c) begin
            lane_d = lane_q + LANE_W'(1);
            if (last_o) begin
                active_d = 1'b0;
            end
        end
    end

    // Burst state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            lane_q   <= '0;
        end else begin
            active_q <= active_d;
            lane_q   <= lane_d;
        end
    end

endmodule

// File: rtl/mac_seq.sv
// Job sequencer for a bank of MAC lanes: clear, accumulate len beats, drain results.
// Optional stall counter enabled by defining MAC_SEQ_PERF_EN.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              len,
    output logic                              busy,
    output logic                              done,
    input  logic                              op_valid,
    output logic                              op_rd,
    output logic                              mac_clr,
    output logic                              mac_en,
    input  logic [NUM_LANES*3*DATA_WIDTH-1:0] cout_in,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [3*DATA_WIDTH-1:0]           res_data,
    output logic [$clog2(NUM_LANES)-1:0]      res_lane,
    output logic [STALL_W-1:0]                stall_cnt
);

    localparam int unsigned RW = 3 * DATA_WIDTH;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 drain_start_c;
    logic                 drain_last_c;

    // Next-state logic and job bookkeeping.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        drain_start_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    len_d   = len;
                    cnt_d   = '0;
                end
            end
            CLEAR: state_d = (len_q != '0) ? ACCUM : DRAIN;
            ACCUM: begin
                if (op_valid) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_start_c = 1'b1;
                state_d       = OUTPUT;
            end
            OUTPUT: begin
                if (drain_last_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control strobes; reset forces the lanes clear and suppresses everything else.
    assign busy    = (state_q != IDLE) & ~rst;
    assign done    = (state_q == DONE) & ~rst;
    assign mac_clr = rst | (state_q == CLEAR);
    assign mac_en  = (state_q == ACCUM) & op_valid & ~rst;
    assign op_rd   = mac_en;

    mac_seq_drain #(
        .RES_WIDTH (RW),
        .NUM_LANES (NUM_LANES)
    ) u_drain (
        .clk         (clk),
        .rst         (rst),
        .start_i     (drain_start_c),
        .cout_i      (cout_in),
        .res_ready_i (res_ready),
        .res_valid_o (res_valid),
        .res_data_o  (res_data),
        .res_lane_o  (res_lane),
        .last_o      (drain_last_c)
    );

`ifdef MAC_SEQ_PERF_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // Count operand-starved accumulate cycles, restarting on each accepted job.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == ACCUM) && !op_valid) begin
            stall_d = sat_inc(stall_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with eight behavioural MAC lanes.
module tb_mac_seq;

`ifdef MAC_SEQ_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   len;
    logic         busy, done;
    logic         op_valid, op_rd;
    logic         mac_clr, mac_en;
    logic [191:0] cout_in;
    logic         res_valid, res_ready;
    logic [23:0]  res_data;
    logic [2:0]   res_lane;
    logic [15:0]  stall_cnt;

    logic [7:0]   a_op [8];
    logic [7:0]   b_op [8];
    logic [23:0]  lane_acc [8];

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0]  got_d [8];
    logic [2:0]   got_l [8];

    typedef struct {
        int               len;
        int               a_mode;      // 0: A=i+1, 1: A=255, 2: A=3
        int               b;
        int               valid_mode;  // 0: always valid, 1: alternate from first ACCUM cycle
        int               stall_lane;  // -1: sink always ready
        int               start_mid;
        int               exp_done;
        int               exp_stall;
        logic [7:0][23:0] exp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    mac_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .op_valid  (op_valid),
        .op_rd     (op_rd),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .cout_in   (cout_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_lane  (res_lane),
        .stall_cnt (stall_cnt)
    );

    // Behavioural MAC lanes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (mac_clr) lane_acc[i] <= '0;
            else if (mac_en) lane_acc[i] <= lane_acc[i] + 24'(a_op[i]) * 24'(b_op[i]);
        end
    end

    always_comb begin
        cout_in = '0;
        for (int i = 0; i < 8; i++) cout_in[i*24 +: 24] = lane_acc[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic run_job(input int vi);
        vec_t v = vecs[vi];
        int cyc = 0;
        int done_cyc = -1;
        int nbeats = 0;
        int nrd = 0;
        int bad_ctl = 0;
        int stable_bad = 0;
        int stall_left = 5;
        int stall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            a_op[i] = (v.a_mode == 0) ? 8'(i + 1) : (v.a_mode == 1) ? 8'd255 : 8'd3;
            b_op[i] = 8'(v.b);
        end
        @(negedge clk);
        len = 4'(v.len);
        start = 1'b1;
        op_valid = 1'b1;
        res_ready = 1'b1;
        while (done_cyc < 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (v.start_mid != 0 && (cyc == 5 || cyc == v.exp_done)) ? 1'b1 : 1'b0;
            if (v.valid_mode == 0 || cyc < 2) op_valid = 1'b1;
            else op_valid = ((cyc - 2) % 2 == 0) ? 1'b1 : 1'b0;
            if (res_valid && int'(res_lane) == v.stall_lane && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            @(negedge clk);
            if (mac_en && mac_clr) bad_ctl++;
            if (op_rd !== mac_en) bad_ctl++;
            if (op_rd) nrd++;
            if (cyc == 1 && busy !== 1'b1) bad_ctl++;
            if (res_valid && !res_ready) begin
                stall_seen++;
                if (int'(res_lane) != v.stall_lane || res_data !== v.exp[v.stall_lane]) stable_bad++;
            end
            if (res_valid && res_ready) begin
                if (nbeats < 8) begin
                    got_d[nbeats] = res_data;
                    got_l[nbeats] = res_lane;
                end
                nbeats++;
            end
            if (done) done_cyc = cyc;
        end
        check($sformatf("v%0d done_cycle", vi), 32'(done_cyc), 32'(v.exp_done));
        check($sformatf("v%0d beat_count", vi), 32'(nbeats), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("v%0d beat%0d data", vi, k), 32'(got_d[k]), 32'(v.exp[k]));
            check($sformatf("v%0d beat%0d lane", vi, k), 32'(got_l[k]), 32'(k));
        end
        check($sformatf("v%0d op_rd_pulses", vi), 32'(nrd), 32'(v.len));
        check($sformatf("v%0d ctl_violations", vi), 32'(bad_ctl), 32'd0);
        if (v.stall_lane >= 0) begin
            check($sformatf("v%0d held_beat_bad", vi), 32'(stable_bad), 32'd0);
            check($sformatf("v%0d held_cycles", vi), 32'(stall_seen), 32'd5);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d busy_after_done", vi), 32'(busy), 32'd0);
        check($sformatf("v%0d done_single", vi), 32'(done), 32'd0);
        check($sformatf("v%0d stall_cnt", vi), 32'(stall_cnt), 32'(v.exp_stall));
    endtask

    initial begin
        int bad;
        vecs[0] = '{len: 4, a_mode: 0, b: 2, valid_mode: 0, stall_lane: -1, start_mid: 0,
                    exp_done: 15, exp_stall: 0,
                    exp: {24'd64, 24'd56, 24'd48, 24'd40, 24'd32, 24'd24, 24'd16, 24'd8}};
        vecs[1] = '{len: 4, a_mode: 0, b: 2, valid_mode: 1, stall_lane: -1, start_mid: 0,
                    exp_done: 18, exp_stall: (PERF != 0) ? 3 : 0,
                    exp: {24'd64, 24'd56, 24'd48, 24'd40, 24'd32, 24'd24, 24'd16, 24'd8}};
        vecs[2] = '{len: 4, a_mode: 0, b: 2, valid_mode: 0, stall_lane: 3, start_mid: 0,
                    exp_done: 20, exp_stall: 0,
                    exp: {24'd64, 24'd56, 24'd48, 24'd40, 24'd32, 24'd24, 24'd16, 24'd8}};
        vecs[3] = '{len: 0, a_mode: 0, b: 2, valid_mode: 0, stall_lane: -1, start_mid: 0,
                    exp_done: 11, exp_stall: 0, exp: '0};
        vecs[4] = '{len: 15, a_mode: 1, b: 255, valid_mode: 0, stall_lane: -1, start_mid: 1,
                    exp_done: 26, exp_stall: 0, exp: {8{24'h0EE20F}}};
        vecs[5] = '{len: 2, a_mode: 2, b: 3, valid_mode: 0, stall_lane: -1, start_mid: 0,
                    exp_done: 13, exp_stall: 0, exp: {8{24'd18}}};

        rst = 1'b1;
        start = 1'b0;
        len = '0;
        op_valid = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst mac_clr", 32'(mac_clr), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst op_rd", 32'(op_rd), 32'd0);
        check("rst mac_en", 32'(mac_en), 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_lane", 32'(res_lane), 32'd0);
        check("rst stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle mac_clr", 32'(mac_clr), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        for (int vi = 0; vi < 5; vi++) run_job(vi);

        // Reset during the second accumulate beat of a len=4 job.
        for (int i = 0; i < 8; i++) begin
            a_op[i] = 8'(i + 1);
            b_op[i] = 8'd2;
        end
        @(negedge clk);
        len = 4'd4;
        start = 1'b1;
        op_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("abort mac_clr", 32'(mac_clr), 32'd1);
        check("abort mac_en", 32'(mac_en), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("abort idle busy", 32'(busy), 32'd0);
        check("abort res_lane", 32'(res_lane), 32'd0);
        check("abort stall_cnt", 32'(stall_cnt), 32'd0);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || res_valid || busy) bad++;
        end
        check("abort quiet", 32'(bad), 32'd0);

        run_job(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
